// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state encoding and helper function for
//               the user-area UART receive path.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
// Contents:
//   OVERSAMPLE, VOTE_LO/MID/HI  oversample ratio and sample points in a bit
//   DATA_BITS                   payload bits per frame (8N1)
//   rx_state_t                  receiver FSM states
//   majority3()                 2-of-3 vote
// =============================================================================
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int SMP_W      = $clog2(OVERSAMPLE);

   // Sample points straddle the bit centre; the last one is also the vote point.
   localparam logic [SMP_W-1:0] VOTE_LO  = SMP_W'(7);
   localparam logic [SMP_W-1:0] VOTE_MID = SMP_W'(8);
   localparam logic [SMP_W-1:0] VOTE_HI  = SMP_W'(9);

   localparam int DATA_BITS = 8;
   localparam int BIT_IDX_W = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_core_if
// Description : Consumer-side bundle of the UART receiver: FIFO head with a
//               valid/ready pop handshake plus the status/interrupt outputs.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
// Signals:
//   rx_data_o     8      FIFO head byte (first-word fall-through)
//   rx_valid_o    1      FIFO non-empty
//   rx_ready_i    1      consumer pop request
//   frame_err_o   1      one-cycle pulse on a bad stop bit
//   overrun_o     1      one-cycle pulse when a good byte is dropped
//   fifo_level_o  LVL_W  FIFO occupancy
//   irq_o         1      interrupt level (mirrors rx_valid_o)
// Modports: master = receiver side, slave = register/Wishbone stage side.
// =============================================================================
interface uart_rx_core_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       rx_data_o;
   logic             rx_valid_o;
   logic             rx_ready_i;
   logic             frame_err_o;
   logic             overrun_o;
   logic [LVL_W-1:0] fifo_level_o;
   logic             irq_o;

   modport master (
      output rx_data_o,
      output rx_valid_o,
      input  rx_ready_i,
      output frame_err_o,
      output overrun_o,
      output fifo_level_o,
      output irq_o
   );

   modport slave (
      input  rx_data_o,
      input  rx_valid_o,
      output rx_ready_i,
      input  frame_err_o,
      input  overrun_o,
      input  fifo_level_o,
      input  irq_o
   );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_fifo
// Description : Small first-word fall-through FIFO for received bytes.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
// Ports:
//   clk_i        in   clock
//   rst_n        in   asynchronous active-low reset
//   push_i       in   write request
//   push_data_i  in   write data
//   pop_i        in   read request (ignored while empty)
//   pop_data_o   out  head entry, forced to 0 while empty
//   valid_o      out  non-empty
//   level_o      out  occupancy 0..FIFO_DEPTH
//   drop_o       out  push refused: full with no simultaneous pop
// =============================================================================
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic [WIDTH-1:0]              push_data_i,
   input  logic                          pop_i,
   output logic [WIDTH-1:0]              pop_data_o,
   output logic                          valid_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          drop_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    count_q;

   logic full;
   logic empty;
   logic pop_fire;
   logic push_fire;

   assign full      = (count_q == LW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign pop_fire  = pop_i && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_fire = push_i && (!full || pop_fire);
   assign drop_o    = push_i && full && !pop_fire;

   // Depth is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_fire, pop_fire})
            2'b10:   count_q <= count_q + LW'(1);
            2'b01:   count_q <= count_q - LW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_fire) mem[wr_ptr_q] <= push_data_i;
   end

   // Storage is not reset; gating keeps the head at 0 whenever it is invalid.
   assign pop_data_o = empty ? '0 : mem[rd_ptr_q];
   assign valid_o    = !empty;
   assign level_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receive front-end with 16x oversampling, 2-of-3
//               majority vote per bit and a first-word fall-through FIFO.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
// Ports:
//   wb_clk_i   in   system clock
//   wb_rst_n   in   asynchronous active-low reset
//   rx_i       in   raw serial line (asynchronous, idles high)
//   rx_en_i    in   receiver enable
//   clk_div_i  in   clock cycles per oversample tick, minus one
//   bus        --   uart_rx_core_if.master: FIFO pop handshake and status
// =============================================================================
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             rx_i,
   input  logic             rx_en_i,
   input  logic [DIV_W-1:0] clk_div_i,
   uart_rx_core_if.master   bus
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]           sync_q;
   logic                 rxs;

   rx_state_t            state_q,   state_d;
   logic                 armed_q,   armed_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0]     div_lat_q, div_lat_d;
   logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
   logic                 s_lo_q,    s_lo_d;
   logic                 s_mid_q,   s_mid_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q;

   logic                 tick;
   logic                 vote_stb;
   logic                 vote;
   logic                 fifo_push;
   logic                 fifo_drop;
   logic                 fifo_valid;
   logic [7:0]           fifo_data;
   logic [LVL_W-1:0]     fifo_level;

   assign rxs      = sync_q[1];
   // Divider only runs while a frame is in progress.
   assign tick     = (state_q != IDLE) && (div_cnt_q == div_lat_q);
   assign vote_stb = tick && (smp_cnt_q == VOTE_HI);
   assign vote     = majority3(s_lo_q, s_mid_q, rxs);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         div_cnt_q   <= '0;
         div_lat_q   <= '0;
         smp_cnt_q   <= '0;
         s_lo_q      <= 1'b0;
         s_mid_q     <= 1'b0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rx_i};
         state_q     <= state_d;
         armed_q     <= armed_d;
         div_cnt_q   <= div_cnt_d;
         div_lat_q   <= div_lat_d;
         smp_cnt_q   <= smp_cnt_d;
         s_lo_q      <= s_lo_d;
         s_mid_q     <= s_mid_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= fifo_drop;
      end
   end

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      div_cnt_d   = div_cnt_q;
      div_lat_d   = div_lat_q;
      smp_cnt_d   = smp_cnt_q;
      s_lo_d      = s_lo_q;
      s_mid_d     = s_mid_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      fifo_push   = 1'b0;

      if (!rx_en_i) begin
         state_d   = IDLE;
         armed_d   = 1'b0;
         div_cnt_d = '0;
         smp_cnt_d = '0;
      end else begin
         if (state_q != IDLE) begin
            if (tick) begin
               div_cnt_d = '0;
               smp_cnt_d = smp_cnt_q + SMP_W'(1);
               if (smp_cnt_q == VOTE_LO)  s_lo_d  = rxs;
               if (smp_cnt_q == VOTE_MID) s_mid_d = rxs;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         case (state_q)
            IDLE: begin
               // Only a high-to-low transition after an observed idle-high
               // line starts a frame; a stuck-low line never retriggers.
               if (rxs) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d   = START;
                  armed_d   = 1'b0;
                  div_cnt_d = '0;
                  smp_cnt_d = '0;
                  div_lat_d = clk_div_i;
               end
            end
            START: begin
               if (vote_stb) begin
                  if (vote) begin
                     state_d = IDLE;
                  end else begin
                     state_d   = DATA;
                     bit_idx_d = '0;
                  end
               end
            end
            DATA: begin
               if (vote_stb) begin
                  shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                  if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) state_d = STOP;
               end
            end
            STOP: begin
               // Leave at the vote point so a back-to-back start edge is
               // not missed while the stop bit finishes.
               if (vote_stb) begin
                  if (vote) fifo_push   = 1'b1;
                  else      frame_err_d = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (DATA_BITS)
   ) u_fifo (
      .clk_i       (wb_clk_i),
      .rst_n       (wb_rst_n),
      .push_i      (fifo_push),
      .push_data_i (shift_q),
      .pop_i       (bus.rx_ready_i),
      .pop_data_o  (fifo_data),
      .valid_o     (fifo_valid),
      .level_o     (fifo_level),
      .drop_o      (fifo_drop)
   );

   assign bus.rx_data_o    = fifo_data;
   assign bus.rx_valid_o   = fifo_valid;
   assign bus.irq_o        = fifo_valid;
   assign bus.fifo_level_o = fifo_level;
   assign bus.frame_err_o  = frame_err_q;
   assign bus.overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// =============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core. Expected bytes
//               are queued as frames are sent and compared on every pop.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_uart_rx_core;
   import uart_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rx_i;
   logic             rx_en_i;
   logic [DIV_W-1:0] clk_div;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   int n_pops   = 0;
   int n_valid  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;

   always #5 clk = ~clk;

   uart_rx_core_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   uart_rx_core #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_n  (rst_n),
      .rx_i      (rx_i),
      .rx_en_i   (rx_en_i),
      .clk_div_i (clk_div),
      .bus       (bus.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: one sample per cycle, just after the falling edge, reflecting
   // what the next rising edge will see.
   always @(negedge clk) begin
      #1;
      if (rst_n === 1'b1) begin
         if (bus.frame_err_o) n_ferr++;
         if (bus.overrun_o)   n_ovr++;
         if (bus.rx_valid_o)  n_valid++;
         if (bus.frame_err_o || bus.overrun_o)
            check("ferr_ovr_exclusive", 32'(bus.frame_err_o & bus.overrun_o), 32'd0);
         if (bus.rx_valid_o && bus.rx_ready_i) begin
            n_pops++;
            check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_byte = exp_q.pop_front();
               check("rx_data", 32'(bus.rx_data_o), 32'(exp_byte));
            end
         end
      end
   end

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Start bit, 8 data bits LSB first, stop bit; leaves the line high.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
      logic [9:0] f;
      int bclk;
      f    = {stop, b, 1'b0};
      bclk = 16 * (div + 1);
      for (int i = 0; i < 10; i++) begin
         rx_i = f[i];
         repeat (bclk) @(negedge clk);
      end
      rx_i = 1'b1;
   endtask

   task automatic drain(input string tag);
      bus.rx_ready_i = 1'b1;
      for (int i = 0; i < 32 && bus.fifo_level_o != 0; i++) @(negedge clk);
      bus.rx_ready_i = 1'b0;
      @(negedge clk);
      check({tag, "_level"}, 32'(bus.fifo_level_o), 32'd0);
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, o0, p0, v0;
      logic [9:0] fr;

      rst_n          = 1'b0;
      rx_i           = 1'b1;
      rx_en_i        = 1'b1;
      clk_div        = 16'd3;
      bus.rx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.rx_valid_o),   32'd0);
      check("rst_level", 32'(bus.fifo_level_o), 32'd0);
      check("rst_data",  32'(bus.rx_data_o),    32'd0);
      check("rst_irq",   32'(bus.irq_o),        32'd0);
      check("rst_ferr",  32'(bus.frame_err_o),  32'd0);
      check("rst_ovr",   32'(bus.overrun_o),    32'd0);
      check("rst_state", 32'(dut.state_q),      32'(IDLE));
      rst_n = 1'b1;
      idle(16);

      // 1: single frame at 64 clk/bit
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 3);
      check("t1_valid", 32'(bus.rx_valid_o),   32'd1);
      check("t1_data",  32'(bus.rx_data_o),    32'hA5);
      check("t1_level", 32'(bus.fifo_level_o), 32'd1);
      check("t1_irq",   32'(bus.irq_o),        32'd1);
      check("t1_ferr_cnt", 32'(n_ferr), 32'd0);
      check("t1_ovr_cnt",  32'(n_ovr),  32'd0);
      drain("t1");

      // 2: short low glitch is a false start
      rx_i = 1'b0;
      repeat (20) @(negedge clk);
      idle(64);
      check("t2_level", 32'(bus.fifo_level_o), 32'd0);
      check("t2_state", 32'(dut.state_q),      32'(IDLE));
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 3);
      idle(16);
      check("t2_level_after", 32'(bus.fifo_level_o), 32'd1);
      drain("t2");

      // 3: bad stop bit
      f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 3);
      idle(64);
      check("t3_ferr_pulses", 32'(n_ferr - f0),     32'd1);
      check("t3_level",       32'(bus.fifo_level_o), 32'd0);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, 3);
      idle(16);
      check("t3_level_after", 32'(bus.fifo_level_o), 32'd1);
      drain("t3");

      // 4a: overflow with no consumer
      o0 = n_ovr;
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1, 3);
         idle(16);
      end
      check("t4a_level",   32'(bus.fifo_level_o), 32'd4);
      check("t4a_overrun", 32'(n_ovr - o0),       32'd1);
      drain("t4a");

      // 4b: pop lands on the 5th push cycle (stop vote at 618 clk after the start edge)
      o0 = n_ovr;
      for (int b = 1; b <= 4; b++) begin
         exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1, 3);
         idle(16);
      end
      exp_q.push_back(8'h05);
      fr = {1'b1, 8'h05, 1'b0};
      for (int i = 0; i < 9; i++) begin
         rx_i = fr[i];
         repeat (64) @(negedge clk);
      end
      rx_i = 1'b1;
      repeat (42) @(negedge clk);
      bus.rx_ready_i = 1'b1;
      @(negedge clk);
      bus.rx_ready_i = 1'b0;
      idle(40);
      check("t4b_level",   32'(bus.fifo_level_o), 32'd4);
      check("t4b_overrun", 32'(n_ovr - o0),       32'd0);
      drain("t4b");

      // 5: asynchronous reset in the middle of data bit 3
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 3);
      idle(16);
      check("t5_pre_valid", 32'(bus.rx_valid_o), 32'd1);
      fr = {1'b1, 8'h77, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rx_i = fr[i];
         repeat (64) @(negedge clk);
      end
      rx_i = fr[4];
      repeat (30) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.rx_valid_o),   32'd0);
      check("t5_rst_level", 32'(bus.fifo_level_o), 32'd0);
      check("t5_rst_data",  32'(bus.rx_data_o),    32'd0);
      check("t5_rst_irq",   32'(bus.irq_o),        32'd0);
      check("t5_rst_ferr",  32'(bus.frame_err_o),  32'd0);
      check("t5_rst_ovr",   32'(bus.overrun_o),    32'd0);
      exp_q.delete();
      @(negedge clk);
      idle(4);
      rst_n = 1'b1;
      idle(32);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 3);
      idle(16);
      check("t5_level", 32'(bus.fifo_level_o), 32'd1);
      check("t5_data",  32'(bus.rx_data_o),    32'h5A);
      drain("t5");

      // 6: back-to-back frames at 16 clk/bit with a consumer always ready
      clk_div        = 16'd0;
      bus.rx_ready_i = 1'b1;
      p0 = n_pops;
      v0 = n_valid;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h00, 1'b1, 0);
      idle(32);
      check("t6_pops",         32'(n_pops - p0),  32'd2);
      check("t6_valid_cycles", 32'(n_valid - v0), 32'd2);

      // 6b: disabling the receiver mid-frame aborts it
      p0 = n_pops;
      f0 = n_ferr;
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_i = fr[i];
         repeat (16) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      rx_en_i = 1'b0;
      idle(40);
      check("t6_abort_state", 32'(dut.state_q), 32'(IDLE));
      rx_en_i = 1'b1;
      idle(200);
      check("t6_abort_pops",  32'(n_pops - p0),     32'd0);
      check("t6_abort_ferr",  32'(n_ferr - f0),     32'd0);
      check("t6_abort_level", 32'(bus.fifo_level_o), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 0);
      idle(32);
      check("t6_recover_pops", 32'(n_pops - p0), 32'd1);
      bus.rx_ready_i = 1'b0;

      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      check("final_ovr_total", 32'(n_ovr), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front-end for the user-area UART. It samples the raw RX pad bit from io_in, recovers 8N1 frames using 16x oversampling and majority voting, and buffers received bytes in a small FIFO. The UART register/Wishbone stage pops bytes through a valid/ready handshake. Status outputs for framing error, overrun and interrupt request feed that stage's status register and user_irq.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
DIV_W, 16, width of the oversample clock divisor

Ports:
wb_clk_i  input  1  system clock; Wishbone clock domain
wb_rst_n  input  1  asynchronous active-low reset
rx_i  input  1  raw serial line from the pad; asynchronous, idles high
rx_en_i  input  1  receiver enable
clk_div_i  input  DIV_W  wb_clk_i cycles per oversample tick, minus one
rx_data_o  output  8  FIFO head byte; first-word fall-through
rx_valid_o  output  1  FIFO non-empty
rx_ready_i  input  1  consumer pop; a pop occurs on valid && ready
frame_err_o  output  1  one-cycle pulse when a stop bit is bad
overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy
irq_o  output  1  level; equals rx_valid_o

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. All counters, FIFO pointers and the synchroniser clear. The synchroniser flops reset to 1. Every output is 0.
- rx_i passes through a 2-flop synchroniser, then is called rxs.
- Tick generator: div_cnt counts from 0 to div_lat. A tick is asserted for one cycle when div_cnt == div_lat, and div_cnt then wraps to 0. div_lat captures clk_div_i on the IDLE->START transition and holds for the whole frame.
- smp_cnt (4 bits) advances on each tick, 0..15. Bit period = 16 ticks. Samples are taken at smp_cnt 7, 8 and 9. At the tick with smp_cnt == 9 the bit value is decided as the 2-of-3 majority of those samples.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: an armed flag sets when rxs == 1. If armed and rxs == 0, go to START and clear div_cnt, smp_cnt and armed. A line held low after reset or after a frame error does not start a frame.
- START: if the vote is 1, it is a false start; return to IDLE. Otherwise go to DATA with bit_idx = 0.
- DATA: each vote shifts into the byte, LSB first. After the vote with bit_idx == 7, go to STOP.
- STOP:
  - Vote 1: push the byte and return to IDLE at the vote cycle, without waiting for the end of the stop bit.
  - Vote 0: pulse frame_err_o, discard the byte, return to IDLE. A new frame requires rxs to return high first (armed rule).
- rx_en_i low: the FSM is forced to IDLE and div_cnt, smp_cnt and armed clear in the same cycle. FIFO contents and the pop path are unaffected.
- FIFO:
  - A push becomes visible on rx_data_o, rx_valid_o and fifo_level_o the cycle after the stop vote.
  - Pop and push in the same cycle: level is unchanged and both take effect.
  - Full with a push and no pop: the byte is dropped and overrun_o pulses.
  - Full with a push and a pop in the same cycle: the push is accepted and there is no overrun.
  - Pointers wrap modulo FIFO_DEPTH; level saturates at FIFO_DEPTH.
- rx_data_o is don't-care when rx_valid_o == 0. A pop request while empty is ignored.
- frame_err_o and overrun_o never pulse on the same cycle by construction.

Decomposition:
- Shared package uart_pkg:
  - OVERSAMPLE = 16, VOTE_LO = 7, VOTE_MID = 8, VOTE_HI = 9, DATA_BITS = 8
  - enum rx_state_t {IDLE, START, DATA, STOP}
- One sub-module: uart_rx_fifo (parameter FIFO_DEPTH, width 8). It has first-word fall-through, push/pop/full/empty/level, and an asynchronous active-low reset on wb_rst_n.
- The FSM, tick generator and synchroniser stay in uart_rx_core.

Test Plan:
1. clk_div_i = 3 (64 clk/bit); send 0xA5 as 8N1 → rx_valid_o = 1 with rx_data_o = 0xA5 within 10 bit-times + 4 clk; frame_err_o and overrun_o stay 0; fifo_level_o = 1; pop → level 0.
2. clk_div_i = 3; rx_i low glitch of 20 clk, then high → no push, FSM back in IDLE, then a 0x3C frame is received correctly.
3. clk_div_i = 3; send 0x3C with the stop bit driven 0 then line high → one-cycle frame_err_o, level unchanged. Next frame 0xC3 is received.
4. FIFO_DEPTH = 4, rx_ready_i = 0; send 0x01..0x05 → level 4, overrun_o pulses once at the 5th stop vote. Draining gives 0x01, 0x02, 0x03, 0x04. Repeat with a pop on the exact cycle of the 5th push → no overrun; drain gives 0x02..0x05.
5. Assert wb_rst_n = 0 during data bit 3 of 0x77 → all outputs 0 asynchronously. Release and send 0x5A → 0x5A received, level 1.
6. rx_ready_i held 1; back-to-back frames 0xFF, 0x00 at clk_div_i = 0 → each byte shows rx_valid_o for exactly one cycle with the correct data. Dropping rx_en_i mid-frame aborts that frame with no push.
